// File: rtl/if_fetch_unit_if.sv
// Bundles the instruction-memory port and the IF/ID handshake of if_fetch_unit.
// master = fetch unit side, slave = memory / decode side.
interface if_fetch_unit_if #(
    parameter int PC_W = 9
);
    logic            id_stall;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            if_id_valid;
    logic [PC_W-1:0] if_id_pc;
    logic [31:0]     if_id_instr;

    modport master (
        input  id_stall,
        input  redirect_en,
        input  redirect_pc,
        input  imem_rdata,
        output imem_req,
        output imem_addr,
        output if_id_valid,
        output if_id_pc,
        output if_id_instr
    );

    modport slave (
        output id_stall,
        output redirect_en,
        output redirect_pc,
        output imem_rdata,
        input  imem_req,
        input  imem_addr,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_instr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle imem reads and queues returned words for IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_squashed counters.
module if_fetch_unit #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              IFQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_unit_if.master   bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);

    localparam int PTR_W = (IFQ_DEPTH > 1) ? $clog2(IFQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  tag_pc_q, tag_pc_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  q_pc_q [IFQ_DEPTH];
    logic [PC_W-1:0]  q_pc_d [IFQ_DEPTH];
    logic [31:0]      q_instr_q [IFQ_DEPTH];
    logic [31:0]      q_instr_d [IFQ_DEPTH];

    logic             req;
    logic             push;
    logic             pop;
    logic             full;
    logic [CNT_W:0]   credit_used;

    // Credit rule: a request is only issued if its response is guaranteed a queue slot.
    // The reset input also gates the strobe so imem_req is low while reset is held.
    always_comb begin
        pop         = (count_q != '0) && !bus.id_stall;
        push        = inflight_q && !bus.redirect_en;
        full        = (count_q == CNT_W'(IFQ_DEPTH));
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        req         = reset && !bus.redirect_en && (credit_used < (CNT_W+1)'(IFQ_DEPTH));
    end

    always_comb begin
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = req;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        if (bus.redirect_en) begin
            pc_d    = bus.redirect_pc & ~PC_W'(3);
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (req) begin
                pc_d     = pc_q + PC_W'(4);
                tag_pc_d = pc_q;
            end
            if (push) begin
                q_pc_d[tail_q]    = tag_pc_q;
                q_instr_d[tail_q] = bus.imem_rdata;
                tail_d            = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < IFQ_DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.if_id_valid = (count_q != '0);
    assign bus.if_id_pc    = q_pc_q[head_q];
    assign bus.if_id_instr = q_instr_q[head_q];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    // A redirect squashes the response arriving this cycle plus every queued entry.
    always_comb begin
        perf_fetched_d  = perf_fetched_q + {31'd0, push};
        perf_squashed_d = perf_squashed_q;
        if (bus.redirect_en) begin
            perf_squashed_d = perf_squashed_q + {31'd0, inflight_q} + 32'(count_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && !pop && full));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed fetch/stall/redirect/reset scenarios plus a
// randomized stall/redirect phase checked against a program-order instruction stream model.
module tb_if_fetch_unit;

    logic clk;
    logic reset;

    int       checks = 0;
    int       errors = 0;
    int       pops   = 0;
    logic [8:0] exp_pc;

    if_fetch_unit_if #(.PC_W(9)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    if_fetch_unit #(
        .PC_W(9),
        .RESET_PC(9'h000),
        .IFQ_DEPTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_squashed(perf_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    // Synchronous memory: data for a request appears during the following cycle, garbage otherwise.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
        else              bus.imem_rdata <= $urandom();
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // The head, whenever valid, must be the next instruction of the program-order stream.
    task automatic apply_stimulus(input logic stall, input logic redir, input logic [8:0] rpc);
        bus.id_stall    = stall;
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;
        #1;
        if (redir) check_output("req_in_redirect", 32'(bus.imem_req), 32'd0);
        if (bus.if_id_valid) begin
            check_output("head_pc", 32'(bus.if_id_pc), 32'(exp_pc));
            check_output("head_instr", bus.if_id_instr, mem_word(exp_pc));
            if (!stall && !redir) begin
                exp_pc = exp_pc + 9'd4;
                pops++;
            end
        end
        if (redir) exp_pc = {rpc[8:2], 2'b00};
    endtask

    initial begin
        reset           = 1'b1;
        bus.id_stall    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = '0;
        exp_pc          = 9'h000;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        check_output("rst_valid", 32'(bus.if_id_valid), 32'd0);
        check_output("rst_pc", 32'(bus.if_id_pc), 32'd0);
        check_output("rst_instr", bus.if_id_instr, 32'd0);
        check_output("rst_req", 32'(bus.imem_req), 32'd0);
        check_output("rst_addr", 32'(bus.imem_addr), 32'h000);

        // T1: straight-line fetch from RESET_PC
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t1_req0", 32'(bus.imem_req), 32'd1);
        check_output("t1_addr0", 32'(bus.imem_addr), 32'h000);
        check_output("t1_valid0", 32'(bus.if_id_valid), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t1_valid1", 32'(bus.if_id_valid), 32'd0);
        check_output("t1_addr1", 32'(bus.imem_addr), 32'h004);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t1_valid2", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t1_valid3", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        check_output("t1_perf_fetched", perf_fetched, 32'd3);
        check_output("t1_perf_squashed", perf_squashed, 32'd0);
`endif

        // T2: stall with 0x008 at the head; queue fills and requests stop
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 9'h0);
            check_output("t2_valid_held", 32'(bus.if_id_valid), 32'd1);
            check_output("t2_req_off", 32'(bus.imem_req), 32'd0);
            @(negedge clk);
        end
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t2_resume_req", 32'(bus.imem_req), 32'd1);
        check_output("t2_resume_addr", 32'(bus.imem_addr), 32'h010);
        @(negedge clk);

        // T3: redirect with a fetch in flight; wrong-path words must never surface
        apply_stimulus(1'b0, 1'b1, 9'h040);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t3_valid_r1", 32'(bus.if_id_valid), 32'd0);
        check_output("t3_addr_r1", 32'(bus.imem_addr), 32'h040);
        check_output("t3_req_r1", 32'(bus.imem_req), 32'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t3_valid_r2", 32'(bus.if_id_valid), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t3_valid_r3", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);

        // T4: unaligned target near the top of the address space, then wrap
        apply_stimulus(1'b0, 1'b1, 9'h1FB);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t4_addr_1f8", 32'(bus.imem_addr), 32'h1F8);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t4_addr_1fc", 32'(bus.imem_addr), 32'h1FC);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t4_addr_wrap", 32'(bus.imem_addr), 32'h000);
        check_output("t4_valid", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);
        repeat (3) begin
            apply_stimulus(1'b0, 1'b0, 9'h0);
            @(negedge clk);
        end

        // T5: redirect while stalled with a full queue
        repeat (3) begin
            apply_stimulus(1'b1, 1'b0, 9'h0);
            @(negedge clk);
        end
        apply_stimulus(1'b1, 1'b1, 9'h080);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 9'h0);
        check_output("t5_valid_r1", 32'(bus.if_id_valid), 32'd0);
        check_output("t5_addr_r1", 32'(bus.imem_addr), 32'h080);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 9'h0);
        check_output("t5_addr_r2", 32'(bus.imem_addr), 32'h084);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 9'h0);
        check_output("t5_valid_r3", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);

        // Randomized stall / redirect traffic against the stream model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 8), 9'($urandom()));
            @(negedge clk);
        end

        // T6: asynchronous reset with a filled queue
        repeat (3) begin
            apply_stimulus(1'b1, 1'b0, 9'h0);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check_output("t6_valid_async", 32'(bus.if_id_valid), 32'd0);
        check_output("t6_req_async", 32'(bus.imem_req), 32'd0);
        check_output("t6_pc_async", 32'(bus.if_id_pc), 32'd0);
        exp_pc = 9'h000;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        check_output("t6_perf_fetched", perf_fetched, 32'd0);
        check_output("t6_perf_squashed", perf_squashed, 32'd0);
`endif
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t6_addr0", 32'(bus.imem_addr), 32'h000);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t6_valid1", 32'(bus.if_id_valid), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 9'h0);
        check_output("t6_valid2", 32'(bus.if_id_valid), 32'd1);
        @(negedge clk);
        repeat (4) begin
            apply_stimulus(1'b0, 1'b0, 9'h0);
            @(negedge clk);
        end

        check_output("throughput", 32'(pops >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
